// File: rtl/ramsdp_reader.sv
// Streaming read engine for a simple-dual-port RAM: issues block reads with a
// credit limit and presents the returned words as a valid/ready stream.
module ramsdp_reader #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);
    localparam logic [1:0]    ST_IDLE  = 2'd0;
    localparam logic [1:0]    ST_READ  = 2'd1;
    localparam logic [1:0]    ST_DRAIN = 2'd2;
    localparam logic [AW:0]   LEN_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [1:0]         state_r, state_nx_s;
    logic [AW:0]        rem_r, rem_nx_s;
    logic               mem_en_r, mem_en_nx_s;
    logic [AW-1:0]      mem_addr_r, mem_addr_nx_s;
    logic               mem_last_r, mem_last_nx_s;
    logic               cap_r, cap_last_r;
    logic [2:0]         cnt_r, cnt_nx_s, wr_idx_s;
    logic [3:0][DW-1:0] buf_data_r, buf_data_nx_s, shift_data_s;
    logic [3:0]         buf_last_r, buf_last_nx_s, shift_last_s;
    logic               out_valid_r, busy_r, done_r, done_nx_s;
    logic               pop_s, last_hs_s, credit_s;

    // Control: state, issue decision for the next cycle, remaining-read counter.
    // The issue is decided one cycle ahead, so the credit test uses next-cycle
    // occupancy plus the read issued this cycle (next cycle's in-flight word).
    always_comb begin
        state_nx_s    = state_r;
        rem_nx_s      = rem_r;
        mem_en_nx_s   = 1'b0;
        mem_addr_nx_s = mem_addr_r;
        mem_last_nx_s = 1'b0;
        done_nx_s     = 1'b0;
        pop_s         = out_valid_r & out_ready;
        last_hs_s     = pop_s & buf_last_r[0];
        cnt_nx_s      = cnt_r + {2'b00, cap_r} - {2'b00, pop_s};
        credit_s      = (cnt_nx_s + {2'b00, mem_en_r}) < 3'd4;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len == {(AW+1){1'b0}}) begin
                        done_nx_s = 1'b1;
                    end else begin
                        state_nx_s    = ST_READ;
                        mem_en_nx_s   = 1'b1;
                        mem_addr_nx_s = base;
                        mem_last_nx_s = (len == LEN_ONE);
                        rem_nx_s      = len - LEN_ONE;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if ((rem_r != {(AW+1){1'b0}}) && credit_s) begin
                    mem_en_nx_s   = 1'b1;
                    mem_addr_nx_s = mem_addr_r + ADDR_ONE;
                    mem_last_nx_s = (rem_r == LEN_ONE);
                    rem_nx_s      = rem_r - LEN_ONE;
                end else begin
                    rem_nx_s = rem_r;
                end
                if (rem_nx_s == {(AW+1){1'b0}}) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (last_hs_s) begin
                    state_nx_s = ST_IDLE;
                    done_nx_s  = 1'b1;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Output buffer: entry 0 is the head; pop shifts down, push lands behind the survivors.
    always_comb begin
        wr_idx_s     = cnt_r - {2'b00, pop_s};
        shift_data_s = pop_s ? {{DW{1'b0}}, buf_data_r[3:1]} : buf_data_r;
        shift_last_s = pop_s ? {1'b0, buf_last_r[3:1]} : buf_last_r;
        for (int i = 0; i < 4; i++) begin
            buf_data_nx_s[i] = (cap_r && (wr_idx_s == 3'(i))) ? mem_dout   : shift_data_s[i];
            buf_last_nx_s[i] = (cap_r && (wr_idx_s == 3'(i))) ? cap_last_r : shift_last_s[i];
        end
    end

    // State and datapath registers; reset discards any in-flight read.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r     <= ST_IDLE;
            rem_r       <= {(AW+1){1'b0}};
            mem_en_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_last_r  <= 1'b0;
            cap_r       <= 1'b0;
            cap_last_r  <= 1'b0;
            cnt_r       <= 3'd0;
            buf_data_r  <= {(4*DW){1'b0}};
            buf_last_r  <= 4'd0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            rem_r       <= rem_nx_s;
            mem_en_r    <= mem_en_nx_s;
            mem_addr_r  <= mem_addr_nx_s;
            mem_last_r  <= mem_last_nx_s;
            cap_r       <= mem_en_r;
            cap_last_r  <= mem_en_r & mem_last_r;
            cnt_r       <= cnt_nx_s;
            buf_data_r  <= buf_data_nx_s;
            buf_last_r  <= buf_last_nx_s;
            out_valid_r <= (cnt_nx_s != 3'd0);
            busy_r      <= (state_nx_s != ST_IDLE);
            done_r      <= done_nx_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign mem_en    = mem_en_r;
    assign mem_addr  = mem_addr_r;
    assign out_valid = out_valid_r;
    assign out_data  = buf_data_r[0];
    assign out_last  = out_valid_r & buf_last_r[0];

endmodule

// File: tb/tb_ramsdp_reader.sv
// Directed bench for ramsdp_reader: a registered-read RAM model feeds the DUT,
// a negedge monitor logs the stream and checks credit and stall rules.
module tb_ramsdp_reader;
    logic        clk;
    logic        nreset;
    logic        start;
    logic [9:0]  base;
    logic [10:0] len;
    logic        busy, done, mem_en, out_valid, out_last, out_ready;
    logic [9:0]  mem_addr;
    logic [15:0] mem_dout = 16'h0000;
    logic [15:0] out_data;

    logic [15:0] ram [1024];

    int n_checks = 0;
    int n_errors = 0;
    int ncyc = 0;
    int n0 = 0;

    logic [15:0] rx_data[$];
    bit          rx_last[$];
    int          rx_cyc[$];
    int          done_cyc[$];
    logic [9:0]  iss_addr[$];

    ramsdp_reader #(.DW(16), .AW(10)) dut (
        .clk(clk), .nreset(nreset), .start(start), .base(base), .len(len),
        .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: one-cycle registered read.
    always @(posedge clk) begin
        if (mem_en) mem_dout <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: occupancy model, credit rule, stall stability, stream log.
    initial begin
        int    bcount;
        int    en_d;
        bit    stall_p;
        bit    hs;
        logic [15:0] pdata;
        logic  plast;
        bcount = 0; en_d = 0; stall_p = 0; pdata = 16'h0000; plast = 1'b0;
        forever begin
            @(negedge clk);
            ncyc = ncyc + 1;
            if (!nreset) begin
                bcount = 0; en_d = 0; stall_p = 0;
            end else begin
                check("valid_model", {31'd0, out_valid}, {31'd0, bcount != 0});
                if (mem_en) begin
                    check("credit", {31'd0, (bcount + en_d) < 4}, 32'd1);
                    iss_addr.push_back(mem_addr);
                end
                if (stall_p) begin
                    check("stall_valid", {31'd0, out_valid}, 32'd1);
                    check("stall_data", {16'd0, out_data}, {16'd0, pdata});
                    check("stall_last", {31'd0, out_last}, {31'd0, plast});
                end
                hs = out_valid & out_ready;
                if (hs) begin
                    rx_data.push_back(out_data);
                    rx_last.push_back(out_last);
                    rx_cyc.push_back(ncyc - n0);
                end
                if (done) done_cyc.push_back(ncyc - n0);
                stall_p = out_valid & !out_ready;
                pdata   = out_data;
                plast   = out_last;
                bcount  = bcount + en_d - (hs ? 1 : 0);
                en_d    = mem_en ? 1 : 0;
            end
        end
    end

    task automatic clear_logs();
        rx_data.delete(); rx_last.delete(); rx_cyc.delete();
        done_cyc.delete(); iss_addr.delete();
    endtask

    task automatic do_start(input logic [9:0] b, input logic [10:0] l);
        @(posedge clk); #1;
        base = b; len = l; start = 1'b1;
        @(posedge clk);
        n0 = ncyc;
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(posedge clk); #1;
            if (rnd) out_ready = ($urandom_range(0, 9) < 7);
            k++;
        end
        check("done_timeout", {31'd0, done}, 32'd1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic check_stream(input int b, input int l, input bit timed);
        check("rx_count", rx_data.size(), l);
        check("done_count", done_cyc.size(), 32'd1);
        check("iss_count", iss_addr.size(), l);
        for (int i = 0; i < rx_data.size() && i < l; i++) begin
            check("data", {16'd0, rx_data[i]}, ((b + i) % 1024) + 256);
            check("last", {31'd0, rx_last[i]}, {31'd0, i == l - 1});
            if (timed) check("word_cyc", rx_cyc[i], i + 3);
        end
        for (int i = 0; i < iss_addr.size() && i < l; i++)
            check("addr", {22'd0, iss_addr[i]}, (b + i) % 1024);
        if (timed && done_cyc.size() == 1) check("done_cyc", done_cyc[0], l + 3);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 16'(i + 256);
        nreset = 1'b0; start = 1'b0; base = 10'd0; len = 11'd0; out_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'd0);
        check("rst_last", {31'd0, out_last}, 32'd0);
        nreset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_mem_en", {31'd0, mem_en}, 32'd0);
        check("idle_valid", {31'd0, out_valid}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Basic: base 4, len 8, ready held high
        clear_logs();
        do_start(10'd4, 11'd8);
        check("busy_c1", {31'd0, busy}, 32'd1);
        wait_done(40, 1'b0);
        check_stream(4, 8, 1'b1);
        check("busy_after", {31'd0, busy}, 32'd0);

        // Backpressure: stall first, then random ready
        clear_logs();
        out_ready = 1'b0;
        do_start(10'h020, 11'd10);
        repeat (8) begin @(posedge clk); #1; end
        check("bp_iss_stalled", iss_addr.size(), 32'd4);
        check("bp_valid_stalled", {31'd0, out_valid}, 32'd1);
        wait_done(200, 1'b1);
        out_ready = 1'b1;
        check_stream(32, 10, 1'b0);

        // Address wrap
        clear_logs();
        do_start(10'h3FE, 11'd4);
        wait_done(40, 1'b0);
        check_stream(1022, 4, 1'b1);

        // Zero length
        clear_logs();
        do_start(10'd7, 11'd0);
        wait_done(10, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check("len0_rx", rx_data.size(), 32'd0);
        check("len0_iss", iss_addr.size(), 32'd0);
        check("len0_done_cnt", done_cyc.size(), 32'd1);
        if (done_cyc.size() == 1) check("len0_done_cyc", done_cyc[0], 32'd1);

        // Full address space
        clear_logs();
        do_start(10'd0, 11'd1024);
        wait_done(1100, 1'b0);
        check_stream(0, 1024, 1'b1);

        // Reset mid-transfer with buffer full
        clear_logs();
        out_ready = 1'b0;
        do_start(10'h040, 11'd16);
        repeat (8) begin @(posedge clk); #1; end
        check("mid_valid", {31'd0, out_valid}, 32'd1);
        nreset = 1'b0;
        #1;
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_mem_en", {31'd0, mem_en}, 32'd0);
        check("mid_addr", {22'd0, mem_addr}, 32'd0);
        check("mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_data", {16'd0, out_data}, 32'd0);
        check("mid_last", {31'd0, out_last}, 32'd0);
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        clear_logs();
        do_start(10'h050, 11'd3);
        wait_done(40, 1'b0);
        check_stream(80, 3, 1'b1);

        // Start while busy is ignored
        clear_logs();
        do_start(10'h060, 11'd6);
        repeat (2) begin @(posedge clk); #1; end
        base = 10'h200; len = 11'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(40, 1'b0);
        repeat (6) begin @(posedge clk); #1; end
        check_stream(96, 6, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
